// File: rtl/generador_mdio_param.sv
// generador_mdio_param
//   MDIO management-frame generator (Clause 22 / Clause 45 framing).
//   A 32-bit frame is latched on an accepted start and shifted out MSB first
//   after an optional all-ones preamble. Read-type frames release the line at
//   the turnaround, check the target's turnaround zero and capture 16 data bits.
//
// Parameters
//   DIV      MDC half-period in clk cycles (1..255)
//   PRE_LEN  preamble length in bits (0..32, 0 = no preamble)
//
// Ports
//   clk          single clock, rising edge
//   reset        synchronous active-high reset
//   start_stb    one-cycle request to launch a frame (ignored while busy)
//   transaccion  frame: ST[31:30] OP[29:28] PHYAD[27:23] REGAD[22:18] TA[17:16] DATA[15:0]
//   mdio_in      MDIO line value driven by the target
//   mdc          management clock
//   mdio_out     MDIO value driven by this block
//   mdio_oe      1 = this block drives MDIO
//   busy         frame in progress
//   data_rdy     one-cycle pulse at the end of a read frame
//   rd_data      data captured by the last completed read frame
//   ta_err       target did not pull the second turnaround bit low on the last read
//
// State   | meaning
// --------+------------------------------------------------------------
// IDLE    | line released, waiting for start_stb
// PREAMBLE| sending PRE_LEN ones
// HEAD    | sending frame bits 31..18 (ST, OP, PHYAD, REGAD)
// TA      | turnaround bits 17..16 (released on reads)
// DATA    | frame bits 15..0 sent (write) or sampled (read)
// DONE    | one cycle after busy falls; data_rdy pulse, start ignored
module generador_mdio_param #(
  parameter int DIV     = 2,
  parameter int PRE_LEN = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_stb,
  input  logic [31:0] transaccion,
  input  logic        mdio_in,
  output logic        mdc,
  output logic        mdio_out,
  output logic        mdio_oe,
  output logic        busy,
  output logic        data_rdy,
  output logic [15:0] rd_data,
  output logic        ta_err
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PREAMBLE = 3'd1;
  localparam logic [2:0] S_HEAD     = 3'd2;
  localparam logic [2:0] S_TA       = 3'd3;
  localparam logic [2:0] S_DATA     = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  // Bit indices are counted over the whole frame, preamble included.
  localparam logic [6:0] HEAD_START = 7'(PRE_LEN);
  localparam logic [6:0] TA_START   = 7'(PRE_LEN + 14);
  localparam logic [6:0] TA2_BIT    = 7'(PRE_LEN + 15);
  localparam logic [6:0] DATA_START = 7'(PRE_LEN + 16);
  localparam logic [6:0] LAST_BIT   = 7'(PRE_LEN + 31);
  localparam logic [7:0] DIV_M1     = 8'(DIV - 1);

  logic [2:0]  state;
  logic [7:0]  div_cnt;
  logic [6:0]  bit_cnt;
  logic [6:0]  bit_nxt;
  logic [31:0] frame_q;
  logic        is_read_q;
  logic [15:0] shift_q;

  assign bit_nxt = bit_cnt + 7'd1;

  function automatic logic read_type(input logic [3:0] st_op);
    // ST=01 OP=10 (C22 read); ST=00 OP=1x (C45 read / post-read-increment)
    return (st_op == 4'b0110) || (st_op[3:1] == 3'b001);
  endfunction

  function automatic logic [2:0] state_for(input logic [6:0] b);
    if (b < HEAD_START)      return S_PREAMBLE;
    else if (b < TA_START)   return S_HEAD;
    else if (b < DATA_START) return S_TA;
    else                     return S_DATA;
  endfunction

  function automatic logic bit_val(input logic [6:0] b, input logic [31:0] fr);
    logic [6:0] f;
    f = b - HEAD_START;
    // frame bit 31-f: for f in 0..31 that index is simply ~f[4:0]
    if (b < HEAD_START) return 1'b1;
    else                return fr[~f[4:0]];
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      div_cnt   <= 8'd0;
      bit_cnt   <= 7'd0;
      frame_q   <= 32'h0;
      is_read_q <= 1'b0;
      shift_q   <= 16'h0;
      mdc       <= 1'b0;
      mdio_out  <= 1'b0;
      mdio_oe   <= 1'b0;
      busy      <= 1'b0;
      data_rdy  <= 1'b0;
      rd_data   <= 16'h0;
      ta_err    <= 1'b0;
    end else begin
      data_rdy <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_stb) begin
            // The acceptance edge is also the start of bit 0.
            frame_q   <= transaccion;
            is_read_q <= read_type(transaccion[31:28]);
            ta_err    <= 1'b0;
            div_cnt   <= 8'd0;
            bit_cnt   <= 7'd0;
            mdc       <= 1'b0;
            busy      <= 1'b1;
            state     <= state_for(7'd0);
            mdio_out  <= bit_val(7'd0, transaccion);
            mdio_oe   <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          if (div_cnt == DIV_M1) begin
            div_cnt <= 8'd0;
            if (!mdc) begin
              // rising mdc: sample the target
              mdc <= 1'b1;
              if (is_read_q && bit_cnt == TA2_BIT && mdio_in) ta_err <= 1'b1;
              if (is_read_q && state == S_DATA) shift_q <= {shift_q[14:0], mdio_in};
            end else begin
              // falling mdc: next bit, or end of frame
              mdc <= 1'b0;
              if (bit_cnt == LAST_BIT) begin
                state    <= S_DONE;
                busy     <= 1'b0;
                mdio_out <= 1'b0;
                mdio_oe  <= 1'b0;
                if (is_read_q) begin
                  data_rdy <= 1'b1;
                  rd_data  <= shift_q;
                end
              end else begin
                bit_cnt  <= bit_nxt;
                state    <= state_for(bit_nxt);
                mdio_out <= bit_val(bit_nxt, frame_q);
                mdio_oe  <= !(is_read_q && bit_nxt >= TA_START);
              end
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_generador_mdio_param.sv
// Bench for generador_mdio_param: two instances (DIV=2/PRE_LEN=32 and
// DIV=2/PRE_LEN=0) driven by directed and random frames, checked cycle by
// cycle against an arithmetic model of the MDIO bit timing.
module tb_generador_mdio_param;

  logic        clk;
  logic        reset     [2];
  logic        start_stb [2];
  logic [31:0] trans     [2];
  logic        mdio_in   [2];
  logic        mdc       [2];
  logic        mdio_out  [2];
  logic        mdio_oe   [2];
  logic        busy      [2];
  logic        data_rdy  [2];
  logic [15:0] rd_data   [2];
  logic        ta_err    [2];

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] exp_rd [2];
  logic        exp_ta [2];

  generador_mdio_param #(.DIV(2), .PRE_LEN(32)) u_pre (
    .clk(clk), .reset(reset[0]), .start_stb(start_stb[0]), .transaccion(trans[0]),
    .mdio_in(mdio_in[0]), .mdc(mdc[0]), .mdio_out(mdio_out[0]), .mdio_oe(mdio_oe[0]),
    .busy(busy[0]), .data_rdy(data_rdy[0]), .rd_data(rd_data[0]), .ta_err(ta_err[0])
  );

  generador_mdio_param #(.DIV(2), .PRE_LEN(0)) u_nopre (
    .clk(clk), .reset(reset[1]), .start_stb(start_stb[1]), .transaccion(trans[1]),
    .mdio_in(mdio_in[1]), .mdc(mdc[1]), .mdio_out(mdio_out[1]), .mdio_oe(mdio_oe[1]),
    .busy(busy[1]), .data_rdy(data_rdy[1]), .rd_data(rd_data[1]), .ta_err(ta_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input int s, input string tag);
    chk({tag, " busy"},     32'(busy[s]),     32'h0);
    chk({tag, " mdc"},      32'(mdc[s]),      32'h0);
    chk({tag, " mdio_out"}, 32'(mdio_out[s]), 32'h0);
    chk({tag, " mdio_oe"},  32'(mdio_oe[s]),  32'h0);
    chk({tag, " data_rdy"}, 32'(data_rdy[s]), 32'h0);
    chk({tag, " rd_data"},  32'(rd_data[s]),  32'(exp_rd[s]));
    chk({tag, " ta_err"},   32'(ta_err[s]),   32'(exp_ta[s]));
  endtask

  function automatic logic is_read(input logic [31:0] tr);
    logic [1:0] st, op;
    st = tr[31:30];
    op = tr[29:28];
    return (st == 2'b01 && op == 2'b10) || (st == 2'b00 && (op == 2'b11 || op == 2'b10));
  endfunction

  // abort_bit < 0: run to completion; otherwise reset at the start of that bit.
  task automatic run_frame(input int s, input logic [31:0] tr, input logic [15:0] resp,
                           input logic ta2, input int abort_bit,
                           input bit extra_start, input bit done_start);
    int p, tot, b, f, ph;
    int e_busy, e_mdc, e_out, e_oe, e_rdy;
    logic rd, x_out, x_oe;
    p   = (s == 0) ? 32 : 0;
    tot = (p + 32) * 4;
    rd  = is_read(tr);
    e_busy = 0; e_mdc = 0; e_out = 0; e_oe = 0; e_rdy = 0;

    @(negedge clk);
    start_stb[s] = 1'b1;
    trans[s]     = tr;
    @(negedge clk);
    start_stb[s] = 1'b0;

    for (int k = 0; k < tot; k++) begin
      b  = k / 4;
      f  = b - p;
      ph = k % 4;
      if (abort_bit >= 0 && k == abort_bit * 4) begin
        reset[s]     = 1'b1;
        start_stb[s] = 1'b1;
        @(negedge clk);
        exp_rd[s] = 16'h0;
        exp_ta[s] = 1'b0;
        chk_idle(s, "abort");
        reset[s]     = 1'b0;
        start_stb[s] = 1'b0;
        @(negedge clk);
        chk("abort stay idle", 32'(busy[s]), 32'h0);
        chk("abort no rdy", 32'(data_rdy[s]), 32'h0);
        return;
      end
      if (b < p) x_out = 1'b1;
      else       x_out = tr[31 - f];
      x_oe = !(rd && f >= 14);
      if (busy[s] !== 1'b1)            e_busy++;
      if (mdc[s] !== (ph >= 2))        e_mdc++;
      if (mdio_out[s] !== x_out)       e_out++;
      if (mdio_oe[s] !== x_oe)         e_oe++;
      if (data_rdy[s] !== 1'b0)        e_rdy++;
      if (rd && f == 15)               mdio_in[s] = ta2;
      else if (rd && f >= 16)          mdio_in[s] = resp[31 - f];
      else                             mdio_in[s] = 1'b1;
      if (extra_start && k == 50) begin
        start_stb[s] = 1'b1;
        trans[s]     = ~tr;
      end else begin
        start_stb[s] = 1'b0;
      end
      @(negedge clk);
    end

    chk("frame busy",     32'(e_busy), 32'h0);
    chk("frame mdc",      32'(e_mdc),  32'h0);
    chk("frame mdio_out", 32'(e_out),  32'h0);
    chk("frame mdio_oe",  32'(e_oe),   32'h0);
    chk("frame data_rdy", 32'(e_rdy),  32'h0);

    // first cycle with busy low
    if (rd) begin
      exp_rd[s] = resp;
      exp_ta[s] = ta2;
    end else begin
      exp_ta[s] = 1'b0;
    end
    chk("end busy",     32'(busy[s]),     32'h0);
    chk("end data_rdy", 32'(data_rdy[s]), 32'(rd));
    chk("end rd_data",  32'(rd_data[s]),  32'(exp_rd[s]));
    chk("end ta_err",   32'(ta_err[s]),   32'(exp_ta[s]));
    chk("end mdc",      32'(mdc[s]),      32'h0);
    chk("end mdio_oe",  32'(mdio_oe[s]),  32'h0);
    chk("end mdio_out", 32'(mdio_out[s]), 32'h0);
    mdio_in[s] = 1'b1;
    if (done_start) begin
      start_stb[s] = 1'b1;
      trans[s]     = tr;
    end
    @(negedge clk);
    start_stb[s] = 1'b0;
    chk("post data_rdy", 32'(data_rdy[s]), 32'h0);
    chk("post busy",     32'(busy[s]),     32'h0);
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      reset[s]     = 1'b1;
      start_stb[s] = 1'b0;
      trans[s]     = 32'h0;
      mdio_in[s]   = 1'b1;
      exp_rd[s]    = 16'h0;
      exp_ta[s]    = 1'b0;
    end
    start_stb[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle(0, "reset pre");
    chk_idle(1, "reset nopre");
    start_stb[0] = 1'b0;
    reset[0] = 1'b0;
    reset[1] = 1'b0;
    @(negedge clk);
    chk("reset start ignored", 32'(busy[0]), 32'h0);

    run_frame(0, 32'h5BA73549, 16'h0000, 1'b0, -1, 1'b0, 1'b0);
    run_frame(0, 32'h65557777, 16'h2468, 1'b0, -1, 1'b0, 1'b0);
    run_frame(1, 32'h3A5C0000, 16'hBEEF, 1'b0, -1, 1'b0, 1'b0);
    run_frame(0, 32'h65557777, 16'hFFFF, 1'b1, -1, 1'b0, 1'b0);
    run_frame(0, 32'h5BA73549, 16'h0000, 1'b0, -1, 1'b1, 1'b1);
    run_frame(0, 32'h65557777, 16'h1357, 1'b0, 40, 1'b0, 1'b0);
    run_frame(0, 32'h5BA73549, 16'h0000, 1'b0, -1, 1'b0, 1'b0);

    for (int i = 0; i < 14; i++) begin
      run_frame(i % 2, $urandom, 16'($urandom), 1'($urandom_range(0, 1)),
                -1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
